// File: rtl/commit_req_queue_s_pkg.sv
// Shared types for the scalar-unit commit requester.
package commit_req_queue_s_pkg;

    localparam int unsigned IssueNoW = 6;

    typedef logic [IssueNoW-1:0] issue_no_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } commit_req_fsm_t;

endpackage

// File: rtl/commit_req_queue_s_if.sv
// Unit/ROB-facing signal bundle of one commit requester instance.
interface commit_req_queue_s_if
    import commit_req_queue_s_pkg::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned WIDTH_NUM = $clog2(DEPTH) + 1;

    logic                 I_Done;
    issue_no_t            I_Done_No;
    logic                 I_Flush;
    logic                 I_Commited;
    logic                 O_Commit_Req;
    issue_no_t            O_Commit_No;
    logic                 O_Full;
    logic                 O_Empty;
    logic [WIDTH_NUM-1:0] O_Num;
    logic                 O_Err;

    // Driven by the functional unit / ROB side.
    modport master (
        output I_Done, I_Done_No, I_Flush, I_Commited,
        input  O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
    );

    // Driven by the commit requester.
    modport slave (
        input  I_Done, I_Done_No, I_Flush, I_Commited,
        output O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
    );

endinterface

// File: rtl/commit_fifo_s.sv
// In-order storage of issue numbers with occupancy count and synchronous flush.
module commit_fifo_s
    import commit_req_queue_s_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned WIDTH_NUM = PtrW + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  issue_no_t            wdata_i,
    output issue_no_t            rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [WIDTH_NUM-1:0] num_o
);

    issue_no_t            mem_q [DEPTH];
    issue_no_t            mem_d [DEPTH];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [WIDTH_NUM-1:0] cnt_q, cnt_d;

    // Next-state for storage, pointers and count; flush wins over push/pop.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + WIDTH_NUM'(1);
                2'b01:   cnt_d = cnt_q - WIDTH_NUM'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == WIDTH_NUM'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign num_o   = cnt_q;

endmodule

// File: rtl/commit_req_queue_s.sv
// Per-unit commit requester: queues completed issue numbers and offers them
// to the ROB one at a time, dropping the request for a cycle after each ack.
module commit_req_queue_s
    import commit_req_queue_s_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    commit_req_queue_s_if.slave bus
);

    localparam int unsigned WIDTH_NUM = $clog2(DEPTH) + 1;

    commit_req_fsm_t      state_q, state_d;
    issue_no_t            commit_no_q, commit_no_d;
    logic                 err_q, err_d;
    logic                 push, pop;
    issue_no_t            head;
    logic                 full, empty;
    logic [WIDTH_NUM-1:0] num;

    commit_fifo_s #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (bus.I_Flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.I_Done_No),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .num_o   (num)
    );

    // Request FSM, queue handshake and sticky error detection.
    always_comb begin
        state_d     = state_q;
        commit_no_d = commit_no_q;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (bus.I_Flush) begin
            state_d     = IDLE;
            commit_no_d = '0;
            err_d       = 1'b0;
        end else begin
            pop  = (state_q == REQ) && bus.I_Commited;
            // A full queue still accepts when its head leaves on the same edge.
            push = bus.I_Done && (!full || pop);
            if (bus.I_Done && full && !pop) err_d = 1'b1;
            if (bus.I_Commited && (state_q == IDLE)) err_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_d     = REQ;
                        commit_no_d = head;
                    end
                end
                REQ: begin
                    if (bus.I_Commited) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            commit_no_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            commit_no_q <= commit_no_d;
            err_q       <= err_d;
        end
    end

    assign bus.O_Commit_Req = (state_q == REQ);
    assign bus.O_Commit_No  = commit_no_q;
    assign bus.O_Full       = full;
    assign bus.O_Empty      = empty;
    assign bus.O_Num        = num;
    assign bus.O_Err        = err_q;

endmodule

// File: tb/tb_commit_req_queue_s.sv
// Bench for commit_req_queue_s: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_commit_req_queue_s;
    import commit_req_queue_s_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    commit_req_queue_s_if #(.DEPTH(DEPTH)) bus ();

    commit_req_queue_s #(
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending issue numbers, request level, number offered, error.
    issue_no_t mq[$];
    bit        m_req;
    issue_no_t m_no;
    bit        m_err;
    issue_no_t acked[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("req",   32'(bus.O_Commit_Req), 32'(m_req));
        check_eq("no",    32'(bus.O_Commit_No),  32'(m_no));
        check_eq("num",   32'(bus.O_Num),        32'(mq.size()));
        check_eq("full",  32'(bus.O_Full),       32'(mq.size() == DEPTH));
        check_eq("empty", 32'(bus.O_Empty),      32'(mq.size() == 0));
        check_eq("err",   32'(bus.O_Err),        32'(m_err));
    endtask

    task automatic model_clear();
        mq.delete();
        m_req = 1'b0;
        m_no  = '0;
        m_err = 1'b0;
    endtask

    // One clock edge of the behavioural rules, applied to the pre-edge state.
    task automatic model_edge(input bit d, input issue_no_t n, input bit a, input bit f);
        bit        nxt_req;
        issue_no_t nxt_no;
        if (f) begin
            model_clear();
            return;
        end
        nxt_req = m_req;
        nxt_no  = m_no;
        if (m_req) begin
            if (a) nxt_req = 1'b0;
        end else if (mq.size() != 0) begin
            nxt_req = 1'b1;
            nxt_no  = mq[0];
        end
        if (a && !m_req) m_err = 1'b1;
        if (a && m_req) begin
            acked.push_back(m_no);
            void'(mq.pop_front());
        end
        if (d) begin
            if (mq.size() < DEPTH) mq.push_back(n);
            else m_err = 1'b1;
        end
        m_req = nxt_req;
        m_no  = nxt_no;
    endtask

    // Check the current state at the falling edge, drive one cycle of inputs.
    task automatic step(input bit d, input issue_no_t n, input bit a, input bit f);
        @(negedge clock);
        check_all();
        bus.I_Done     = d;
        bus.I_Done_No  = n;
        bus.I_Commited = a;
        bus.I_Flush    = f;
        @(posedge clock);
        model_edge(d, n, a, f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b0;
        bus.I_Done     = 1'b0;
        bus.I_Done_No  = '0;
        bus.I_Commited = 1'b0;
        bus.I_Flush    = 1'b0;
        model_clear();
        acked.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        int        next;
        bit        d;
        bit        a;
        bit        f;
        issue_no_t n;

        bus.I_Done     = 1'b0;
        bus.I_Done_No  = '0;
        bus.I_Commited = 1'b0;
        bus.I_Flush    = 1'b0;
        model_clear();

        // Reset state.
        do_reset();
        check_all();

        // Single: enqueue 5, request two cycles later, ack, queue empties.
        step(1, 6'd5, 0, 0);
        step(0, 0, 0, 0);
        check_eq("single_req", 32'(bus.O_Commit_Req), 32'd1);
        check_eq("single_no",  32'(bus.O_Commit_No),  32'd5);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("single_req_drop", 32'(bus.O_Commit_Req), 32'd0);
        check_eq("single_empty",    32'(bus.O_Empty),      32'd1);

        // Burst: 1,2,3 acked on the first REQ cycle each.
        do_reset();
        for (int i = 0; i < 12; i++) step(i < 3, issue_no_t'(i + 1), m_req, 0);
        check_eq("burst_count", 32'(acked.size()), 32'd3);
        for (int i = 0; i < acked.size() && i < 3; i++)
            check_eq("burst_order", 32'(acked[i]), 32'(i + 1));

        // Full, overflow, then drain across pointer wrap.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, issue_no_t'(i), 0, 0);
        check_eq("full_flag", 32'(bus.O_Full), 32'd1);
        check_eq("full_num",  32'(bus.O_Num),  32'd8);
        step(1, 6'd40, 0, 0);
        check_eq("ovf_err", 32'(bus.O_Err), 32'd1);
        check_eq("ovf_num", 32'(bus.O_Num), 32'd8);
        next = 9;
        for (int k = 0; k < 60; k++) begin
            d = (next <= 18) && (mq.size() < DEPTH);
            step(d, issue_no_t'(next), m_req, 0);
            if (d) next++;
        end
        check_eq("wrap_count", 32'(acked.size()), 32'd18);
        for (int i = 0; i < acked.size() && i < 18; i++)
            check_eq("wrap_order", 32'(acked[i]), 32'(i + 1));

        // Simultaneous enqueue and pop on a full queue.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, issue_no_t'(i), 0, 0);
        step(1, 6'd9, 1, 0);
        check_eq("simul_num", 32'(bus.O_Num), 32'd8);
        check_eq("simul_err", 32'(bus.O_Err), 32'd0);
        for (int k = 0; k < 40; k++) step(0, 0, m_req, 0);
        check_eq("simul_count", 32'(acked.size()), 32'd9);
        if (acked.size() == 9) check_eq("simul_last", 32'(acked[8]), 32'd9);

        // Flush during a request with a coincident ack.
        do_reset();
        step(1, 6'd1, 0, 0);
        step(1, 6'd2, 0, 0);
        check_eq("flush_pre_req", 32'(bus.O_Commit_Req), 32'd1);
        check_eq("flush_pre_no",  32'(bus.O_Commit_No),  32'd1);
        step(1, 6'd3, 0, 0);
        step(0, 0, 1, 1);
        check_eq("flush_req",   32'(bus.O_Commit_Req), 32'd0);
        check_eq("flush_num",   32'(bus.O_Num),        32'd0);
        check_eq("flush_err",   32'(bus.O_Err),        32'd0);
        check_eq("flush_empty", 32'(bus.O_Empty),      32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("spurious_err", 32'(bus.O_Err), 32'd1);

        // Asynchronous reset between edges while requesting.
        do_reset();
        step(1, 6'd7, 0, 0);
        step(0, 0, 0, 0);
        check_eq("arst_pre_req", 32'(bus.O_Commit_Req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_req",   32'(bus.O_Commit_Req), 32'd0);
        check_eq("arst_no",    32'(bus.O_Commit_No),  32'd0);
        check_eq("arst_num",   32'(bus.O_Num),        32'd0);
        check_eq("arst_empty", 32'(bus.O_Empty),      32'd1);
        check_eq("arst_full",  32'(bus.O_Full),       32'd0);
        check_eq("arst_err",   32'(bus.O_Err),        32'd0);
        model_clear();
        acked.delete();
        @(negedge clock);
        reset = 1'b1;
        #1;

        // Random traffic including overflow, spurious acks and flushes.
        for (int k = 0; k < 2000; k++) begin
            d = ($urandom_range(0, 2) == 0) &&
                ((mq.size() < DEPTH) || ($urandom_range(0, 7) == 0));
            n = issue_no_t'($urandom);
            a = m_req ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 59) == 0);
            step(d, n, a, f);
        end
        step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
